// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution load controller.
package conv_pkg;

  localparam int unsigned NUM_PE_DEF = 16;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 20;

  // Load mode encoding
  localparam logic [1:0] MODE_IFM   = 2'b00;
  localparam logic [1:0] MODE_W     = 2'b01;
  localparam logic [1:0] MODE_IFM_W = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD_IFM,
    S_LOAD_W,
    S_DONE
  } state_t;

endpackage

// File: rtl/conv_load_ctrl_if.sv
// Source stream and BRAM write ports of the convolution load controller.
interface conv_load_ctrl_if
  import conv_pkg::*;
#(
  parameter int unsigned NUM_PE = NUM_PE_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  logic              wr_en_IFM;
  logic [ADDR_W-1:0] addr_IFM;
  logic [DATA_W-1:0] data_IFM;

  logic [NUM_PE-1:0] wr_en_Weight;
  logic [ADDR_W-1:0] addr_Weight;
  logic [DATA_W-1:0] data_Weight;

  modport master (
    output s_valid, s_data,
    input  s_ready,
    input  wr_en_IFM, addr_IFM, data_IFM,
    input  wr_en_Weight, addr_Weight, data_Weight
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready,
    output wr_en_IFM, addr_IFM, data_IFM,
    output wr_en_Weight, addr_Weight, data_Weight
  );

endinterface

// File: rtl/load_addr_cnt.sv
// Up-counter with synchronous load, enable, and terminal-count flag.
// Wraps to zero when enabled at the terminal value.
module load_addr_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == last);

  // count register: load has priority over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/conv_load_ctrl.sv
// Streams IFM and PE weight words from a source stream into BRAM write ports.
module conv_load_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned NUM_PE = NUM_PE_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned TILE   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [7:0]             IFM_W,
  input  logic [7:0]             IFM_C,
  input  logic [3:0]             KERNEL_W,
  conv_load_ctrl_if.slave        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int unsigned BYTES     = DATA_W / 8;
  localparam int unsigned BANK_W    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [32:0] ADDR_SPAN = 33'(1) << ADDR_W;

  state_t            state, state_nx;
  logic [1:0]        mode_q;
  logic [31:0]       n_ifm, n_w;
  logic              cfg_bad;
  logic [ADDR_W-1:0] n_ifm_last, n_w_last, addr_last, addr_cnt;
  logic [BANK_W-1:0] bank_cnt;
  logic              addr_tc, bank_tc;
  logic              s_ready_i, xfer;

  // word counts and configuration check from the live inputs (used in CFG)
  always_comb begin
    n_ifm   = (32'(IFM_W) * 32'(IFM_W) * 32'(IFM_C)) / 32'(BYTES);
    n_w     = (32'(IFM_C) * 32'(KERNEL_W) * 32'(KERNEL_W) * 32'(TILE)) / 32'(BYTES);
    cfg_bad = (mode == MODE_RSVD) || (KERNEL_W == 4'd0) || (IFM_W == 8'd0) ||
              (IFM_C == 8'd0) || (((32'(IFM_C) * 32'd8) % 32'(DATA_W)) != 32'd0) ||
              ({1'b0, n_ifm} > ADDR_SPAN) || ({1'b0, n_w} > ADDR_SPAN);
  end

  // configuration latched in CFG; later input changes are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= MODE_IFM;
      n_ifm_last <= '0;
      n_w_last   <= '0;
    end else if (state == S_CFG) begin
      mode_q     <= mode;
      n_ifm_last <= ADDR_W'(n_ifm - 32'd1);
      n_w_last   <= ADDR_W'(n_w - 32'd1);
    end
  end

  // an abort discards the beat presented in the same cycle
  assign xfer      = bus.s_valid && s_ready_i && !abort;
  assign addr_last = (state == S_LOAD_W) ? n_w_last : n_ifm_last;

  // word address wraps to 0 at each phase/bank boundary through its terminal count
  load_addr_cnt #(.W(ADDR_W)) u_addr_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state == S_CFG),
    .load_val ('0),
    .en       (xfer),
    .last     (addr_last),
    .cnt      (addr_cnt),
    .tc       (addr_tc)
  );

  load_addr_cnt #(.W(BANK_W)) u_bank_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state == S_CFG),
    .load_val ('0),
    .en       (xfer && addr_tc && (state == S_LOAD_W)),
    .last     (BANK_W'(NUM_PE - 1)),
    .cnt      (bank_cnt),
    .tc       (bank_tc)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_CFG;
      S_CFG: begin
        if (abort || cfg_bad)       state_nx = S_IDLE;
        else if (mode == MODE_W)    state_nx = S_LOAD_W;
        else                        state_nx = S_LOAD_IFM;
      end
      S_LOAD_IFM: begin
        if (abort)                  state_nx = S_IDLE;
        else if (xfer && addr_tc)   state_nx = (mode_q == MODE_IFM_W) ? S_LOAD_W : S_DONE;
      end
      S_LOAD_W: begin
        if (abort)                          state_nx = S_IDLE;
        else if (xfer && addr_tc && bank_tc) state_nx = S_DONE;
      end
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    s_ready_i = (state == S_LOAD_IFM) || (state == S_LOAD_W);
    done      = (state == S_DONE);
  end

  assign bus.s_ready = s_ready_i;

  // registered write ports and status; busy tracks the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy             <= 1'b0;
      cfg_err          <= 1'b0;
      bus.wr_en_IFM    <= 1'b0;
      bus.addr_IFM     <= '0;
      bus.data_IFM     <= '0;
      bus.wr_en_Weight <= '0;
      bus.addr_Weight  <= '0;
      bus.data_Weight  <= '0;
    end else begin
      busy             <= (state_nx != S_IDLE);
      cfg_err          <= (state == S_CFG) && !abort && cfg_bad;
      bus.wr_en_IFM    <= xfer && (state == S_LOAD_IFM);
      bus.wr_en_Weight <= (xfer && (state == S_LOAD_W)) ? (NUM_PE'(1) << bank_cnt) : '0;
      if (xfer && (state == S_LOAD_IFM)) begin
        bus.addr_IFM <= addr_cnt;
        bus.data_IFM <= bus.s_data;
      end
      if (xfer && (state == S_LOAD_W)) begin
        bus.addr_Weight <= addr_cnt;
        bus.data_Weight <= bus.s_data;
      end
    end
  end

endmodule

// File: tb/tb_conv_load_ctrl.sv
// Randomized self-checking bench for conv_load_ctrl against a transfer-index model.
module tb_conv_load_ctrl;

  localparam int unsigned NPE = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 20;
  localparam int unsigned TL  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] ifm_w = 8'd0, ifm_c = 8'd0;
  logic [3:0] kernel_w = 4'd0;
  logic       busy, done, cfg_err;

  int n_vec = 0;
  int n_err = 0;

  conv_load_ctrl_if #(.NUM_PE(NPE), .DATA_W(DW), .ADDR_W(AW)) bus ();

  conv_load_ctrl #(.NUM_PE(NPE), .DATA_W(DW), .ADDR_W(AW), .TILE(TL)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .IFM_W    (ifm_w),
    .IFM_C    (ifm_c),
    .KERNEL_W (kernel_w),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_no_write(input string tag);
    chk_val({tag, "_ifm_en"}, bus.wr_en_IFM, 0);
    chk_val({tag, "_w_en"}, bus.wr_en_Weight, 0);
  endtask

  // Reference: word counts and legality straight from the arithmetic rules
  task automatic model_cfg(input logic [1:0] md, input logic [7:0] w, input logic [7:0] c,
                           input logic [3:0] kw, output longint n_ifm, output longint n_w,
                           output longint total, output bit bad);
    longint span;
    span  = longint'(1) << AW;
    n_ifm = (longint'(w) * w * c) / (DW / 8);
    n_w   = (longint'(c) * kw * kw * TL) / (DW / 8);
    bad   = (md == 2'd3) || (kw == 0) || (w == 0) || (c == 0) ||
            (((longint'(c) * 8) % DW) != 0) || (n_ifm > span) || (n_w > span);
    case (md)
      2'd0:    total = n_ifm;
      2'd1:    total = n_w * NPE;
      default: total = n_ifm + n_w * NPE;
    endcase
  endtask

  // One load: abort_at / rst_at are transfer indices at which to abort / reset (-1 = never)
  task automatic run_load(input logic [1:0] md, input logic [7:0] w, input logic [7:0] c,
                          input logic [3:0] kw, input int vpct,
                          input longint abort_at, input longint rst_at);
    longint n_ifm, n_w, total, k, j, cyc, budget, p_bank, p_addr;
    bit bad, pend, p_ifm, fin;
    logic [31:0] p_data;
    model_cfg(md, w, c, kw, n_ifm, n_w, total, bad);

    @(negedge clk);
    mode = md; ifm_w = w; ifm_c = c; kernel_w = kw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_val("cfg_busy", busy, 1);
    chk_val("cfg_ready", bus.s_ready, 0);

    if (bad) begin
      @(negedge clk);
      chk_val("cfg_err_pulse", cfg_err, 1);
      chk_val("cfg_err_busy", busy, 0);
      chk_val("cfg_err_ready", bus.s_ready, 0);
      chk_no_write("cfg_err");
      @(negedge clk);
      chk_val("cfg_err_end", cfg_err, 0);
      chk_val("cfg_err_ready2", bus.s_ready, 0);
      chk_no_write("cfg_err2");
      return;
    end

    k = 0; pend = 0; cyc = 0; fin = 0;
    p_ifm = 0; p_bank = 0; p_addr = 0; p_data = '0;
    budget = (total * 300) / vpct + 50;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        if (p_ifm) begin
          chk_val("ifm_en", bus.wr_en_IFM, 1);
          chk_val("ifm_addr", bus.addr_IFM, p_addr);
          chk_val("ifm_data", bus.data_IFM, p_data);
          chk_val("ifm_w_en", bus.wr_en_Weight, 0);
        end else begin
          chk_val("w_en", bus.wr_en_Weight, 64'd1 << p_bank);
          chk_val("w_addr", bus.addr_Weight, p_addr);
          chk_val("w_data", bus.data_Weight, p_data);
          chk_val("w_ifm_en", bus.wr_en_IFM, 0);
        end
      end else begin
        chk_no_write("stall");
      end
      chk_val("done", done, pend && (k == total));
      chk_val("busy", busy, 1);
      chk_val("s_ready", bus.s_ready, k < total);

      if (k == total) begin
        start = 1'b0; bus.s_valid = 1'b0;
        @(negedge clk);
        chk_val("end_busy", busy, 0);
        chk_val("end_done", done, 0);
        chk_val("end_ready", bus.s_ready, 0);
        chk_no_write("end");
        fin = 1;
      end else if (k == abort_at) begin
        abort = 1'b1; bus.s_valid = 1'b1; bus.s_data = $urandom; start = 1'b0;
        @(negedge clk);
        abort = 1'b0; bus.s_valid = 1'b0;
        chk_val("abort_busy", busy, 0);
        chk_val("abort_done", done, 0);
        chk_val("abort_ready", bus.s_ready, 0);
        chk_no_write("abort");
        fin = 1;
      end else if (k == rst_at) begin
        bus.s_valid = 1'b0; start = 1'b0; reset = 1'b0;
        #1;
        chk_no_write("rst");
        chk_val("rst_addr_w", bus.addr_Weight, 0);
        chk_val("rst_data_w", bus.data_Weight, 0);
        chk_val("rst_addr_i", bus.addr_IFM, 0);
        chk_val("rst_data_i", bus.data_IFM, 0);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_done", done, 0);
        chk_val("rst_cfg_err", cfg_err, 0);
        chk_val("rst_ready", bus.s_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        fin = 1;
      end else if (cyc > budget) begin
        chk_val("timeout_beats", k, total);
        bus.s_valid = 1'b0; start = 1'b0; reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        fin = 1;
      end else begin
        mode = 2'($urandom); ifm_w = 8'($urandom); ifm_c = 8'($urandom);
        kernel_w = 4'($urandom); start = ($urandom_range(7) == 0);
        bus.s_valid = ($urandom_range(99) < vpct);
        bus.s_data  = $urandom;
        pend = bus.s_valid;
        if (pend) begin
          if ((md != 2'd1) && (k < n_ifm)) begin
            p_ifm = 1; p_addr = k; p_bank = 0;
          end else begin
            j = k - ((md == 2'd1) ? 0 : n_ifm);
            p_ifm = 0; p_bank = j / n_w; p_addr = j % n_w;
          end
          p_data = bus.s_data;
          k++;
        end
      end
    end
    bus.s_valid = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    #2 reset = 1'b0;
    #1;
    chk_no_write("reset");
    chk_val("reset_busy", busy, 0);
    chk_val("reset_done", done, 0);
    chk_val("reset_cfg_err", cfg_err, 0);
    chk_val("reset_ready", bus.s_ready, 0);
    chk_val("reset_addr_i", bus.addr_IFM, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_load(2'd0, 8'd58, 8'd32, 4'd3, 100, -1, -1);
    run_load(2'd1, 8'd8, 8'd32, 4'd3, 100, -1, -1);
    run_load(2'd2, 8'd8, 8'd8, 4'd3, 60, -1, -1);

    run_load(2'd0, 8'd8, 8'd6, 4'd3, 100, -1, -1);
    run_load(2'd3, 8'd8, 8'd8, 4'd3, 100, -1, -1);
    run_load(2'd1, 8'd8, 8'd8, 4'd0, 100, -1, -1);
    run_load(2'd0, 8'd0, 8'd8, 4'd3, 100, -1, -1);
    run_load(2'd2, 8'd8, 8'd0, 4'd3, 100, -1, -1);
    run_load(2'd0, 8'd255, 8'd252, 4'd3, 100, -1, -1);

    run_load(2'd0, 8'd16, 8'd8, 4'd3, 100, 100, -1);
    run_load(2'd0, 8'd16, 8'd8, 4'd3, 100, -1, -1);
    run_load(2'd2, 8'd4, 8'd4, 4'd2, 70, 16 + 37, -1);

    run_load(2'd1, 8'd8, 8'd8, 4'd2, 100, -1, 5 * 64 + 10);
    run_load(2'd1, 8'd8, 8'd8, 4'd2, 100, -1, -1);

    for (int i = 0; i < 4; i++) begin
      run_load(2'($urandom_range(2)), 8'($urandom_range(12, 1)), 8'(4 * $urandom_range(2, 1)),
               4'($urandom_range(2, 1)), int'($urandom_range(100, 40)), -1, -1);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
